// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: conversion request/result bundle between a requester and the bin2bcd_seq converter
interface bin2bcd_seq_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           ovf;
  logic [7*D-1:0] HEX;
  modport master (output start, bin, input busy, done, bcd, ovf, HEX);
  modport slave  (input start, bin, output busy, done, bcd, ovf, HEX);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with seven-segment decode
module bin2bcd_seq #(
  parameter int W   = 8,
  parameter int D   = 3,
  parameter bit LZB = 1'b1
) (
  input logic Clock,
  input logic Reset,
  bin2bcd_seq_if.slave io
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state_q, state_d;
  logic [4*D-1:0] dig_q, dig_d, adj, bcd_q, bcd_d;
  logic [4*D:0]   sh;
  logic [W-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           of_q, of_d, ovf_q, ovf_d;
  logic [7*D-1:0] hex;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  // one double-dabble step: add 3 to digits >= 5, then shift {digits, binary} left; the bit leaving the top digit is overflow
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < D; i++)
      adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
    sh = {adj, sr_q[W-1]};
  end

  // state and datapath registers, asynchronously cleared
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // next state: capture on start, W shift steps, one done cycle; results load on the last step
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    of_d    = of_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (io.start) begin
        sr_d    = io.bin;
        dig_d   = '0;
        cnt_d   = '0;
        of_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        dig_d = sh[4*D-1:0];
        sr_d  = sr_q << 1;
        of_d  = of_q | sh[4*D];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          bcd_d   = sh[4*D-1:0];
          ovf_d   = of_q | sh[4*D];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // display decode from the registered result; z tracks "this and all higher digits are zero"
  always_comb begin
    logic z;
    hex = '1;
    z   = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      z = z & (bcd_q[4*i +: 4] == 4'd0);
      hex[7*i +: 7] = (LZB && i > 0 && z) ? 7'h7F : seg(bcd_q[4*i +: 4]);
    end
  end

  assign io.busy = (state_q == SHIFT);
  assign io.done = (state_q == DONE);
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;
  assign io.HEX  = hex;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: three converter variants driven in parallel, checked against an arithmetic model every cycle
module tb_bin2bcd_seq;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin   = 8'd0;
  bit         en    = 1'b0;
  int         tests = 0;
  int         fails = 0;

  bin2bcd_seq_if #(.W(8), .D(3)) ia ();
  bin2bcd_seq_if #(.W(8), .D(2)) ib ();
  bin2bcd_seq_if #(.W(8), .D(3)) ic ();
  assign ia.start = start;
  assign ia.bin   = bin;
  assign ib.start = start;
  assign ib.bin   = bin;
  assign ic.start = start;
  assign ic.bin   = bin;

  bin2bcd_seq #(.W(8), .D(3), .LZB(1'b1)) dut_a (.Clock(Clock), .Reset(Reset), .io(ia));
  bin2bcd_seq #(.W(8), .D(2), .LZB(1'b1)) dut_b (.Clock(Clock), .Reset(Reset), .io(ib));
  bin2bcd_seq #(.W(8), .D(3), .LZB(1'b0)) dut_c (.Clock(Clock), .Reset(Reset), .io(ic));

  always #5 Clock = ~Clock;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'h40;
      1: glyph = 7'h79;
      2: glyph = 7'h24;
      3: glyph = 7'h30;
      4: glyph = 7'h19;
      5: glyph = 7'h12;
      6: glyph = 7'h02;
      7: glyph = 7'h78;
      8: glyph = 7'h00;
      default: glyph = 7'h10;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    int p = 1;
    to_bcd = '0;
    for (int i = 0; i < 3; i++) begin
      to_bcd[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
  endfunction

  function automatic logic [20:0] hex_exp(input int v, input int d, input bit lzb);
    int p = 1;
    hex_exp = '1;
    for (int i = 0; i < d; i++) begin
      hex_exp[7*i +: 7] = (lzb && i > 0 && v < p) ? 7'h7F : glyph((v / p) % 10);
      p *= 10;
    end
  endfunction

  // model: a start seen while idle yields busy for 8 cycles then a one-cycle done, result = captured value
  logic m_busy = 1'b0, m_done = 1'b0;
  int   m_cnt = 0, m_res = 0;
  logic [7:0] m_val = 8'd0;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= int'(m_val);
      end
    end else if (m_done) m_done <= 1'b0;
    else if (start) begin
      m_busy <= 1'b1;
      m_cnt  <= 8;
      m_val  <= bin;
    end
  end

  always @(negedge Clock) begin
    logic [20:0] h;
    logic [11:0] b;
    if (en) begin
      check("A.busy", 32'(ia.busy), 32'(m_busy));
      check("A.done", 32'(ia.done), 32'(m_done));
      check("A.bcd", 32'(ia.bcd), 32'(to_bcd(m_res % 1000)));
      check("A.ovf", 32'(ia.ovf), 32'(m_res >= 1000));
      check("A.HEX", 32'(ia.HEX), 32'(hex_exp(m_res % 1000, 3, 1'b1)));
      check("B.busy", 32'(ib.busy), 32'(m_busy));
      check("B.done", 32'(ib.done), 32'(m_done));
      b = to_bcd(m_res % 100);
      check("B.bcd", 32'(ib.bcd), 32'(b[7:0]));
      check("B.ovf", 32'(ib.ovf), 32'(m_res >= 100));
      h = hex_exp(m_res % 100, 2, 1'b1);
      check("B.HEX", 32'(ib.HEX), 32'(h[13:0]));
      check("C.busy", 32'(ic.busy), 32'(m_busy));
      check("C.done", 32'(ic.done), 32'(m_done));
      check("C.bcd", 32'(ic.bcd), 32'(to_bcd(m_res % 1000)));
      check("C.HEX", 32'(ic.HEX), 32'(hex_exp(m_res % 1000, 3, 1'b0)));
    end
  end

  // issue a start, optionally re-pulse start with av at loop step alt, scramble bin meanwhile, wait for done
  task automatic conv(input logic [7:0] v, input int alt, input logic [7:0] av);
    int bc = 0;
    int i  = 0;
    bin = v; start = 1'b1;
    @(posedge Clock); #1;
    while (!ia.done && i < 30) begin
      if (ia.busy) bc++;
      start = (i == alt);
      bin   = (i == alt) ? av : ~v;
      @(posedge Clock); #1;
      i++;
    end
    start = 1'b0;
    check("done_seen", 32'(ia.done), 32'd1);
    check("busy_cycles", 32'(bc), 32'd8);
  endtask

  // one cycle after done: optional start held during DONE must be ignored, done must be one cycle wide
  task automatic tail(input bit hold);
    start = hold; bin = 8'd200;
    @(posedge Clock); #1;
    start = 1'b0;
    check("done_width", 32'(ia.done), 32'd0);
    check("start_in_done_ignored", 32'(ia.busy), 32'd0);
  endtask

  initial begin
    #2 Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0; en = 1'b1;
    check("rst.A.HEX", 32'(ia.HEX), 32'({7'h7F, 7'h7F, 7'h40}));
    check("rst.B.HEX", 32'(ib.HEX), 32'({7'h7F, 7'h40}));
    check("rst.C.HEX", 32'(ic.HEX), 32'({7'h40, 7'h40, 7'h40}));
    check("rst.A.bcd", 32'(ia.bcd), 32'h0);
    conv(8'd0, -1, 8'd0);
    check("zero.A.bcd", 32'(ia.bcd), 32'h000);
    check("zero.A.HEX", 32'(ia.HEX), 32'({7'h7F, 7'h7F, 7'h40}));
    tail(1'b0);
    conv(8'd255, -1, 8'd0);
    check("255.A.bcd", 32'(ia.bcd), 32'h255);
    check("255.A.ovf", 32'(ia.ovf), 32'd0);
    check("255.A.HEX", 32'(ia.HEX), 32'({7'h24, 7'h12, 7'h12}));
    check("255.B.bcd", 32'(ib.bcd), 32'h55);
    check("255.B.ovf", 32'(ib.ovf), 32'd1);
    tail(1'b0);
    conv(8'd42, -1, 8'd0);
    check("42.B.bcd", 32'(ib.bcd), 32'h42);
    check("42.B.ovf", 32'(ib.ovf), 32'd0);
    check("42.A.HEX", 32'(ia.HEX), 32'({7'h7F, 7'h19, 7'h24}));
    tail(1'b0);
    conv(8'd99, 3, 8'd200);
    check("99.A.bcd", 32'(ia.bcd), 32'h099);
    check("99.A.HEX", 32'(ia.HEX), 32'({7'h7F, 7'h10, 7'h10}));
    tail(1'b0);
    repeat (12) @(posedge Clock);
    #1 check("no_second_done", 32'(ia.done), 32'd0);
    bin = 8'd123; start = 1'b1;
    @(posedge Clock); #1 start = 1'b0;
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("abort.busy", 32'(ia.busy), 32'd0);
    check("abort.done", 32'(ia.done), 32'd0);
    check("abort.bcd", 32'(ia.bcd), 32'h0);
    check("abort.ovf", 32'(ib.ovf), 32'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    conv(8'd7, -1, 8'd0);
    check("7.A.bcd", 32'(ia.bcd), 32'h007);
    check("7.A.HEX", 32'(ia.HEX), 32'({7'h7F, 7'h7F, 7'h78}));
    check("7.C.HEX", 32'(ic.HEX), 32'({7'h40, 7'h40, 7'h78}));
    tail(1'b1);
    repeat (12) @(posedge Clock);
    #1 check("7.C.bcd_kept", 32'(ic.bcd), 32'h007);
    conv(8'd58, -1, 8'd0);
    check("58.C.bcd", 32'(ic.bcd), 32'h058);
    tail(1'b0);
    repeat (3) @(posedge Clock);
    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter W, default 8, the binary input width (W >= 1).
REQ-002 The block SHALL have parameter D, default 3, the number of BCD digits and seven-segment displays (D >= 1).
REQ-003 The block SHALL have parameter LZB, default 1; 1 blanks leading zero digits, 0 shows all digits.

Ports:
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: conversion request, sampled on a rising Clock edge.
REQ-007 The block SHALL have port bin, input, W bits: the unsigned binary value, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse on completion.
REQ-010 The block SHALL have port bcd, output, 4*D bits: the registered result, with digit i on bits [4i+3:4i] and digit 0 the least significant.
REQ-011 The block SHALL have port ovf, output, 1 bit: high when the last result did not fit in D digits.
REQ-012 The block SHALL have port HEX, output, 7*D bits: active-low segments, with display i on bits [7i+6:7i], segment a on bit 0 through g on bit 6.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture bin into a shift register, clear the BCD working register and iteration counter, and enter SHIFT; busy SHALL be 1 from that edge onward.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble step:
- add 3 to every working digit >= 5;
- then shift the combined {digits, binary} register left by one bit.
REQ-016 SHIFT SHALL last exactly W cycles; on the W-th step edge the block SHALL load bcd and ovf from the working result and enter DONE.
REQ-017 In DONE, done SHALL be 1 and busy 0 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be fixed: with start accepted at edge k, bcd/ovf update and done rises after edge k+W, and done falls after edge k+W+1.
REQ-019 A start asserted while in SHIFT or DONE SHALL be ignored; no queueing.
REQ-020 Changes on bin after capture SHALL NOT affect the conversion in progress.
REQ-021 The bcd and ovf outputs SHALL hold the previous result until the next completion.
REQ-022 Overflow handling:
- ovf SHALL be set if any 1 is shifted out of the top digit during the conversion;
- bcd SHALL then equal the value mod 10^D, with every digit still in 0-9.
REQ-023 Display i SHALL show the standard active-low glyph of digit i (0-9). Codes 10-15 SHALL blank the display (all ones).
REQ-024 When LZB=1, display i (i>0) SHALL be blanked if it and every more significant digit are 0; display 0 SHALL never be blanked.
REQ-025 HEX SHALL be a combinational decode of the registered bcd only, never of the working register.
REQ-026 All arithmetic SHALL be unsigned. The iteration counter SHALL be ceil(log2(W+1)) bits and SHALL NOT wrap within a conversion.

Reset
REQ-027 When Reset=1, the block SHALL, asynchronously:
- force the FSM to IDLE;
- drive busy=0, done=0, bcd=0, ovf=0;
- clear the working registers and counter.
REQ-028 After reset, HEX SHALL show "0" on display 0; the other displays SHALL be blank (LZB=1) or "0" (LZB=0).
REQ-029 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse. start SHALL be accepted at the first edge after Reset falls.

Verification
REQ-030 With W=8, D=3, LZB=1: reset, then start with bin=0 -> done 9 cycles later, bcd=0x000, ovf=0, HEX1/HEX2 blank, HEX0="0".
REQ-031 With W=8, D=3: bin=255 -> bcd=0x255, ovf=0, done pulse exactly one cycle wide, busy high for exactly 8 cycles.
REQ-032 With W=8, D=3: start with bin=99, pulse start again mid-conversion with bin=200 -> single done, bcd=0x099, HEX2 blank.
REQ-033 With W=8, D=2: bin=255 -> bcd=0x55, ovf=1; a following bin=42 -> bcd=0x42, ovf=0.
REQ-034 With W=8, D=3: Reset asserted 4 cycles into a conversion of 123 -> no done pulse, all outputs 0; a new start with 7 -> bcd=0x007.
REQ-035 With W=8, D=3, LZB=0: bin=7 -> HEX2 and HEX1 show "0" and HEX0 shows "7"; back-to-back starts issued in DONE are ignored.
